// File: rtl/m_s_ip_arb_pkg.sv
// Interrupt bit positions, privilege encodings and cause types shared by the
// mip/sip pending logic and the interrupt arbiter.
package m_s_ip_arb_pkg;

  localparam int SSI = 1;
  localparam int MSI = 3;
  localparam int STI = 5;
  localparam int MTI = 7;
  localparam int SEI = 9;
  localparam int MEI = 11;

  localparam int CAUSE_W = 4;

  localparam logic [1:0] PRIV_U = 2'd0;
  localparam logic [1:0] PRIV_S = 2'd1;
  localparam logic [1:0] PRIV_M = 2'd3;

  // Implemented interrupt bits, and the subset that may be delegated to S.
  localparam logic [11:0] IRQ_MASK   = 12'hAAA;
  localparam logic [11:0] DELEG_MASK = 12'h222;

  typedef logic [CAUSE_W-1:0] cause_t;

  typedef struct packed {
    logic   valid;
    cause_t cause;
    logic   to_s;
  } irq_sel_t;

  function automatic cause_t to_cause(input int idx);
    return cause_t'(idx);
  endfunction

endpackage

// File: rtl/m_s_ip_arb_if.sv
// Request/acknowledge channel between the interrupt arbiter and the trap unit.
interface m_s_ip_arb_if;
  import m_s_ip_arb_pkg::*;

  logic   int_req;
  cause_t int_cause;
  logic   int_to_s;
  logic   int_ack;

  modport master (output int_req, output int_cause, output int_to_s, input int_ack);
  modport slave  (input int_req, input int_cause, input int_to_s, output int_ack);

endinterface

// File: rtl/m_s_ip_arb_int_sync_2ff.sv
// Multi-flop level synchronizer for an asynchronous interrupt line.
module int_sync_2ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/m_s_ip_arb.sv
// mip/sip pending bits plus a single-outstanding interrupt arbiter that offers
// one latched cause to the trap unit over a req/ack handshake.
module m_s_ip_arb
  import m_s_ip_arb_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m_ext_int,
  input  logic        s_ext_int,
  input  logic        m_tmr_int,
  input  logic        m_soft_int,
  input  logic        mrw_mip_sel,
  input  logic        srw_sip_sel,
  input  logic        csr_write,
  input  logic [63:0] data_csr,
  input  logic [63:0] m_s_ie,
  input  logic [63:0] mideleg,
  input  logic        mstatus_mie,
  input  logic        mstatus_sie,
  input  logic [1:0]  priv,
  output logic [63:0] m_s_ip,
  output logic [63:0] s_ip,
  m_s_ip_arb_if.master trap
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ---------------------------------------------------------------- sync
  logic [3:0] async_lvl;
  logic [3:0] sync_lvl;

  assign async_lvl = {m_soft_int, m_tmr_int, s_ext_int, m_ext_int};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sync
      int_sync_2ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (async_lvl[gi]),
        .q_o (sync_lvl[gi])
      );
    end
  endgenerate

  logic meip_sync, seip_sync, mtip_sync, msip_sync;
  assign meip_sync = sync_lvl[0];
  assign seip_sync = sync_lvl[1];
  assign mtip_sync = sync_lvl[2];
  assign msip_sync = sync_lvl[3];

  // ------------------------------------------------------ software bits
  logic ssip_q, stip_q, seip_q;
  logic ssip_d, stip_d, seip_d;

  always_comb begin
    ssip_d = ssip_q;
    stip_d = stip_q;
    seip_d = seip_q;
    if (csr_write && mrw_mip_sel) begin
      ssip_d = data_csr[SSI];
      stip_d = data_csr[STI];
      seip_d = data_csr[SEI];
    end else if (csr_write && srw_sip_sel) begin
      ssip_d = data_csr[SSI];
    end
  end

  // ------------------------------------------------------- pending view
  logic [11:0] pend;

  always_comb begin
    pend      = '0;
    pend[MEI] = meip_sync;
    pend[MTI] = mtip_sync;
    pend[MSI] = msip_sync;
    pend[SEI] = seip_q | seip_sync;
    pend[STI] = stip_q;
    pend[SSI] = ssip_q;
  end

  logic [11:0] deleg;
  assign deleg  = mideleg[11:0] & DELEG_MASK;
  assign m_s_ip = {52'b0, pend};
  assign s_ip   = {52'b0, pend & deleg};

  // -------------------------------------------------------- eligibility
  logic        m_en, s_en;
  logic [11:0] active, elig_m, elig_s;

  assign m_en   = (priv != PRIV_M) || mstatus_mie;
  assign s_en   = (priv == PRIV_U) || ((priv == PRIV_S) && mstatus_sie);
  assign active = pend & m_s_ie[11:0] & IRQ_MASK;
  assign elig_m = active & ~deleg & {12{m_en}};
  assign elig_s = active &  deleg & {12{s_en}};

  // Fixed order within a destination class: 11, 3, 7, 9, 1, 5.
  function automatic cause_t pick(input logic [11:0] v);
    if      (v[MEI]) return to_cause(MEI);
    else if (v[MSI]) return to_cause(MSI);
    else if (v[MTI]) return to_cause(MTI);
    else if (v[SEI]) return to_cause(SEI);
    else if (v[SSI]) return to_cause(SSI);
    else             return to_cause(STI);
  endfunction

  irq_sel_t sel;

  always_comb begin
    sel = '0;
    if (|elig_m) begin
      sel.valid = 1'b1;
      sel.cause = pick(elig_m);
      sel.to_s  = 1'b0;
    end else if (|elig_s) begin
      sel.valid = 1'b1;
      sel.cause = pick(elig_s);
      sel.to_s  = 1'b1;
    end
  end

  // ----------------------------------------------------------------- FSM
  logic [1:0] state_q, state_d;
  cause_t     cause_q, cause_d;
  logic       to_s_q, to_s_d;
  logic       latched_elig;

  // The latched source is re-checked in the class it was granted under.
  assign latched_elig = to_s_q ? elig_s[cause_q] : elig_m[cause_q];

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    to_s_d  = to_s_q;
    case (state_q)
      ST_IDLE: begin
        if (sel.valid) begin
          state_d = ST_REQ;
          cause_d = sel.cause;
          to_s_d  = sel.to_s;
        end
      end
      ST_REQ: begin
        if (trap.int_ack) begin
          state_d = ST_DRAIN;
        end else if (!latched_elig) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cause_q <= '0;
      to_s_q  <= 1'b0;
      ssip_q  <= 1'b0;
      stip_q  <= 1'b0;
      seip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      to_s_q  <= to_s_d;
      ssip_q  <= ssip_d;
      stip_q  <= stip_d;
      seip_q  <= seip_d;
    end
  end

  assign trap.int_req   = (state_q == ST_REQ);
  assign trap.int_cause = cause_q;
  assign trap.int_to_s  = to_s_q;

  logic unused_bits;
  assign unused_bits = ^{data_csr[63:10], data_csr[8:6], data_csr[4:2], data_csr[0],
                         m_s_ie[63:12], mideleg[63:12]};

endmodule

// File: doc/m_s_ip_arb.md
Name: m_s_ip_arb

Overview:
Holds the mip/sip pending bits and arbitrates enabled, pending interrupts into a single trap request toward the trap/exception unit. It consumes the mie/sie enable vector and the delegation and global-enable state. It presents one latched cause with a req/ack handshake. It sits beside the mie/sie CSR block in the CU/RU CSR group and feeds the trap entry logic.

Parameters:
SYNC_STAGES, 2, synchronizer depth on asynchronous interrupt inputs (min 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
m_ext_int  in  1  async M external interrupt level (PLIC)
s_ext_int  in  1  async S external interrupt level (PLIC)
m_tmr_int  in  1  async machine timer level (CLINT)
m_soft_int  in  1  async machine software level (CLINT)
mrw_mip_sel  in  1  CSR access targets mip
srw_sip_sel  in  1  CSR access targets sip
csr_write  in  1  CSR write strobe
data_csr  in  64  CSR write data
m_s_ie  in  64  current mie vector (bits 1,3,5,7,9,11 valid)
mideleg  in  64  delegation vector; only bits 1,5,9 honoured
mstatus_mie  in  1  global M enable
mstatus_sie  in  1  global S enable
priv  in  2  current privilege (0 U, 1 S, 3 M)
int_ack  in  1  trap unit accepted current request
int_req  out  1  interrupt request
int_cause  out  4  cause code of request (1,3,5,7,9,11)
int_to_s  out  1  request traps to S mode (delegated)
m_s_ip  out  64  mip read value
s_ip  out  64  sip read value

Behaviour:
- Reset: all synchronizer flops, ssip/stip/seip regs = 0; state IDLE; int_req=0, int_cause=0, int_to_s=0.
- Async inputs pass through SYNC_STAGES flops. Input level to mip visibility = SYNC_STAGES cycles.
- Pending bits:
  - MEIP(11), MTIP(7), MSIP(3) = synchronized inputs; read-only.
  - SEIP(9) = seip_reg | sync(s_ext_int).
  - STIP(5) = stip_reg.
  - SSIP(1) = ssip_reg.
- Writes take effect next cycle:
  - mrw_mip_sel & csr_write: ssip_reg<=d[1], stip_reg<=d[5], seip_reg<=d[9].
  - srw_sip_sel & csr_write: ssip_reg<=d[1] only.
  - mip select wins if both selects are set.
- m_s_ip = 52'b0 with bits {11,9,7,5,3,1} as above. Read SEIP includes the external level.
- s_ip = bits 9,5,1 of mip masked by mideleg bits 9,5,1; all other bits 0.
- Eligibility for bit i: pend[i] & m_s_ie[i].
  - Not delegated (i in {3,7,11}, or mideleg[i]=0): enabled if priv!=3, or priv==3 & mstatus_mie.
  - Delegated (i in {1,5,9}, mideleg[i]=1): enabled if priv==0, or priv==1 & mstatus_sie. Never taken while priv==3.
- Priority: any M-destined interrupt beats any S-destined one. Within each class the order is 11, 3, 7, 9, 1, 5.
- FSM IDLE / REQ / DRAIN:
  - IDLE: if any eligible, latch cause and dest next edge, go to REQ, int_req=1.
  - REQ: int_cause and int_to_s are frozen, even if a higher priority interrupt arrives.
    - int_ack=1: go to DRAIN, int_req=0 next cycle.
    - Else, if the latched source is no longer eligible (pending dropped, enable cleared, priv/global-enable changed): withdraw, int_req=0 next cycle, go to IDLE.
    - If ack and withdraw occur in the same cycle, ack wins.
  - DRAIN: one cycle with no request, letting trap entry update priv and mstatus. Then go to IDLE.
- Latency: eligible source in IDLE -> int_req high at the next edge (1 cycle).
- int_ack outside REQ is ignored.
- rst mid-request: everything returns to reset values next edge; no ack is expected afterwards.

Decomposition:
- Shared CSR package holds:
  - interrupt bit index constants: SSI=1, MSI=3, STI=5, MTI=7, SEI=9, MEI=11
  - privilege encodings
  - cause width constant 4
- One natural sub-module: int_sync_2ff, a parameterised SYNC_STAGES synchronizer instantiated four times.
- The priority encoder stays inline.

Test Plan:
1. Reset, then raise m_tmr_int with mie[7]=1, priv=0 -> m_s_ip[7]=1 after 2 cycles; int_req=1, int_cause=7, int_to_s=0 one cycle later. Ack -> int_req=0 for DRAIN, then re-request (level still high).
2. Simultaneous pending on 11, 3, 7, 9 (all enabled, none delegated, priv=0) -> cause 11. Hold without ack, then raise nothing new; clear mie[11] -> int_req drops next cycle. IDLE then re-arbitrates to cause 3.
3. mideleg[5]=1, write mip d=0x20, mie[5]=1, priv=3 -> no request. Switch to priv=1 with mstatus_sie=1 -> int_req=1, cause 5, int_to_s=1. sip read = 0x20.
4. sip write 0x222 -> only SSIP set (mip=0x002). mip write 0x222 -> mip=0x222. Assert s_ext_int, then write mip 0 -> SEIP still reads 1.
5. In REQ with cause 9, assert MEI eligible -> cause remains 9 until ack. After DRAIN, the next request is cause 11.
6. Assert rst while int_req=1 -> next cycle int_req=0, int_cause=0, ssip/stip/seip=0.
